// File: rtl/rp_pio_error_controller.sv
// rp_pio_error_controller
//
// Root Port PIO error-reporting sequencer. Accepts one completion-error event
// at a time, qualifies it against MASK, records it in STATUS, captures the
// 4-DW TLP header for the first unmasked error, then raises one-cycle
// System Error / DPC trigger notifications. All registers are visible on a
// simple word-addressed software port.
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   err_valid / err_ready    event handshake
//   err_space, err_kind      event classification (3 = invalid in either)
//   err_hdr                  TLP header, DW0 in [31:0]
//   sw_wr, sw_addr, sw_wdata software register write
//   sw_rdata                 combinational read data for sw_addr
//   sys_err_o, dpc_trig_o    one-cycle notification pulses
//
// Register map (word address): 0 STATUS (RW1C), 1 MASK, 2 SEVERITY,
// 3 SYSERR, 4 FIRST_ERR (RO: [31]=valid, [4:0]=pointer), 5..8 HDR_LOG0..3.
// Status bit index = 8*space + kind.

module rp_pio_error_controller (
  input  logic         clk,
  input  logic         rst,
  input  logic         err_valid,
  output logic         err_ready,
  input  logic [1:0]   err_space,
  input  logic [1:0]   err_kind,
  input  logic [127:0] err_hdr,
  input  logic         sw_wr,
  input  logic [3:0]   sw_addr,
  input  logic [31:0]  sw_wdata,
  output logic [31:0]  sw_rdata,
  output logic         sys_err_o,
  output logic         dpc_trig_o
);

  localparam logic [31:0] VALID_BITS = 32'h0007_0707;

  typedef enum logic [1:0] {IDLE, EVAL, LOG, NOTIFY} state_t;

  state_t         state_q, state_d;
  logic [1:0]     space_q, space_d;
  logic [1:0]     kind_q, kind_d;
  logic [127:0]   hdr_q, hdr_d;
  logic [1:0]     cnt_q, cnt_d;
  logic [31:0]    status_q, status_d;
  logic [31:0]    mask_q, mask_d;
  logic [31:0]    sev_q, sev_d;
  logic [31:0]    syserr_q, syserr_d;
  logic [4:0]     ptr_q, ptr_d;
  logic           valid_q, valid_d;
  logic [31:0]    hdr_log_q [4];
  logic [31:0]    hdr_log_d [4];

  logic [4:0]     bit_idx;
  logic           evt_invalid;
  logic [31:0]    hw_set;
  logic [31:0]    sw_w1c;
  logic           capture;

  // space occupies bits [4:3] and kind bits [1:0], i.e. 8*space + kind
  assign bit_idx     = {space_q, 1'b0, kind_q};
  assign evt_invalid = (space_q == 2'd3) || (kind_q == 2'd3);

  always_comb begin
    state_d   = state_q;
    space_d   = space_q;
    kind_d    = kind_q;
    hdr_d     = hdr_q;
    cnt_d     = cnt_q;
    mask_d    = mask_q;
    sev_d     = sev_q;
    syserr_d  = syserr_q;
    ptr_d     = ptr_q;
    valid_d   = valid_q;
    hdr_log_d = hdr_log_q;
    hw_set    = '0;
    capture   = 1'b0;
    sw_w1c    = (sw_wr && sw_addr == 4'd0) ? (sw_wdata & VALID_BITS) : '0;

    if (sw_wr) begin
      case (sw_addr)
        4'd1:    mask_d   = sw_wdata & VALID_BITS;
        4'd2:    sev_d    = sw_wdata & VALID_BITS;
        4'd3:    syserr_d = sw_wdata & VALID_BITS;
        default: ;
      endcase
    end

    case (state_q)
      IDLE: begin
        if (err_valid) begin
          space_d = err_space;
          kind_d  = err_kind;
          hdr_d   = err_hdr;
          state_d = EVAL;
        end
      end
      EVAL: begin
        if (evt_invalid || mask_q[bit_idx]) begin
          state_d = IDLE;
        end else begin
          hw_set = 32'd1 << bit_idx;
          if (!valid_q) begin
            capture = 1'b1;
            ptr_d   = bit_idx;
            cnt_d   = 2'd0;
            state_d = LOG;
          end else begin
            state_d = NOTIFY;
          end
        end
      end
      LOG: begin
        // A software clear here does not stop the capture; all 4 DWs land.
        hdr_log_d[cnt_q] = hdr_q[{cnt_q, 5'd0} +: 32];
        cnt_d            = cnt_q + 2'd1;
        if (cnt_q == 2'd3) state_d = NOTIFY;
      end
      NOTIFY: begin
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // Hardware set beats a simultaneous software clear of the same bit.
    status_d = (status_q & ~sw_w1c) | hw_set;

    // Clearing the bit the pointer refers to re-arms the header log, unless
    // that bit is being set again on the same edge.
    if (capture) begin
      valid_d = 1'b1;
    end else if (valid_q && sw_w1c[ptr_q] && !hw_set[ptr_q]) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      space_q  <= '0;
      kind_q   <= '0;
      hdr_q    <= '0;
      cnt_q    <= '0;
      status_q <= '0;
      mask_q   <= VALID_BITS;
      sev_q    <= VALID_BITS;
      syserr_q <= '0;
      ptr_q    <= '0;
      valid_q  <= 1'b0;
      for (int i = 0; i < 4; i++) hdr_log_q[i] <= '0;
    end else begin
      state_q  <= state_d;
      space_q  <= space_d;
      kind_q   <= kind_d;
      hdr_q    <= hdr_d;
      cnt_q    <= cnt_d;
      status_q <= status_d;
      mask_q   <= mask_d;
      sev_q    <= sev_d;
      syserr_q <= syserr_d;
      ptr_q    <= ptr_d;
      valid_q  <= valid_d;
      for (int i = 0; i < 4; i++) hdr_log_q[i] <= hdr_log_d[i];
    end
  end

  always_comb begin
    case (sw_addr)
      4'd0:    sw_rdata = status_q;
      4'd1:    sw_rdata = mask_q;
      4'd2:    sw_rdata = sev_q;
      4'd3:    sw_rdata = syserr_q;
      4'd4:    sw_rdata = {valid_q, 26'd0, ptr_q};
      4'd5:    sw_rdata = hdr_log_q[0];
      4'd6:    sw_rdata = hdr_log_q[1];
      4'd7:    sw_rdata = hdr_log_q[2];
      4'd8:    sw_rdata = hdr_log_q[3];
      default: sw_rdata = '0;
    endcase
  end

  // Notifications come only from registered state; reset suppresses them.
  assign err_ready  = (state_q == IDLE);
  assign sys_err_o  = (state_q == NOTIFY) && syserr_q[bit_idx] && !rst;
  assign dpc_trig_o = (state_q == NOTIFY) && sev_q[bit_idx] && !rst;

endmodule

// File: tb/tb_rp_pio_error_controller.sv
// Testbench for rp_pio_error_controller: table of single-event vectors,
// hand-written multi-cycle sequences, and a randomized run against a
// register-level reference model.

module tb_rp_pio_error_controller;

  localparam logic [31:0] VALID_BITS = 32'h0007_0707;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         err_valid = 1'b0;
  logic         err_ready;
  logic [1:0]   err_space = '0;
  logic [1:0]   err_kind = '0;
  logic [127:0] err_hdr = '0;
  logic         sw_wr = 1'b0;
  logic [3:0]   sw_addr = '0;
  logic [31:0]  sw_wdata = '0;
  logic [31:0]  sw_rdata;
  logic         sys_err_o;
  logic         dpc_trig_o;

  int checks = 0;
  int failures = 0;

  rp_pio_error_controller dut (
    .clk(clk), .rst(rst),
    .err_valid(err_valid), .err_ready(err_ready),
    .err_space(err_space), .err_kind(err_kind), .err_hdr(err_hdr),
    .sw_wr(sw_wr), .sw_addr(sw_addr), .sw_wdata(sw_wdata), .sw_rdata(sw_rdata),
    .sys_err_o(sys_err_o), .dpc_trig_o(dpc_trig_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] mask;
    logic [31:0] sev;
    logic [31:0] syserr;
    logic [1:0]  sp;
    logic [1:0]  kd;
    logic [31:0] expStatus;
    logic [31:0] expFirst;
    int          expReady;
    int          expSys;
    int          expDpc;
  } vec_t;

  vec_t vecs [7];

  // Reference model state
  logic [31:0] mStatus, mMask, mSev, mSys;
  logic [4:0]  mPtr;
  logic        mValid;
  logic [31:0] mLog [4];

  // Stimulus result holders
  int          readyCyc, sysCnt, dpcCnt, pulseCyc;
  logic [31:0] st2, fe2, rd;

  task automatic checkOutput(input string name, input logic [127:0] actual,
                             input logic [127:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s actual=0x%0h expected=0x%0h", name, actual, expected);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic readReg(input logic [3:0] a, output logic [31:0] d);
    sw_addr = a;
    #1;
    d = sw_rdata;
  endtask

  task automatic swWrite(input logic [3:0] a, input logic [31:0] d);
    sw_wr = 1'b1;
    sw_addr = a;
    sw_wdata = d;
    tick;
    sw_wr = 1'b0;
  endtask

  task automatic doReset;
    rst = 1'b1;
    err_valid = 1'b0;
    sw_wr = 1'b0;
    tick;
    tick;
    rst = 1'b0;
  endtask

  function automatic logic [31:0] resetValue(input int a);
    if (a == 1 || a == 2) return VALID_BITS;
    return 32'h0;
  endfunction

  task automatic checkResetState(input string tag);
    logic [31:0] v;
    checkOutput({tag, "_err_ready"}, err_ready, 1'b1);
    checkOutput({tag, "_sys_err"}, sys_err_o, 1'b0);
    checkOutput({tag, "_dpc_trig"}, dpc_trig_o, 1'b0);
    for (int a = 0; a < 16; a++) begin
      readReg(a[3:0], v);
      checkOutput($sformatf("%s_reg%0d", tag, a), v, resetValue(a));
    end
  endtask

  // Offers one event while the DUT is idle and follows it until err_ready
  // returns. Cycle 1 is the cycle after the handshake edge.
  task automatic applyStimulus(input logic [1:0] sp, input logic [1:0] kd,
                               input logic [127:0] hdr,
                               output int rc, output int sc, output int dc,
                               output int pc, output logic [31:0] s2,
                               output logic [31:0] f2);
    rc = -1; sc = 0; dc = 0; pc = -1; s2 = '0; f2 = '0;
    err_space = sp;
    err_kind = kd;
    err_hdr = hdr;
    err_valid = 1'b1;
    tick;
    err_valid = 1'b0;
    for (int c = 1; c <= 20; c++) begin
      if (sys_err_o) begin sc++; pc = c; end
      if (dpc_trig_o) begin dc++; pc = c; end
      if (c == 2) begin
        readReg(4'd0, s2);
        readReg(4'd4, f2);
      end
      if (err_ready) begin
        rc = c;
        break;
      end
      tick;
    end
  endtask

  task automatic modelWrite(input logic [3:0] a, input logic [31:0] d);
    case (a)
      4'd0: begin
        if (mValid && d[mPtr] && VALID_BITS[mPtr]) mValid = 1'b0;
        mStatus = mStatus & ~(d & VALID_BITS);
      end
      4'd1: mMask = d & VALID_BITS;
      4'd2: mSev = d & VALID_BITS;
      4'd3: mSys = d & VALID_BITS;
      default: ;
    endcase
  endtask

  task automatic modelReset;
    mStatus = 0; mMask = VALID_BITS; mSev = VALID_BITS; mSys = 0;
    mPtr = 0; mValid = 0;
    for (int i = 0; i < 4; i++) mLog[i] = 0;
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog timeout");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    logic [127:0] hdrA, hdrB, hdrC;
    int pulses;

    vecs[0] = '{32'h0, VALID_BITS, VALID_BITS, 2'd2, 2'd2, 32'h0004_0000, 32'h8000_0012, 7, 1, 1};
    vecs[1] = '{VALID_BITS, VALID_BITS, 32'h0, 2'd0, 2'd0, 32'h0, 32'h0, 2, 0, 0};
    vecs[2] = '{32'h0, 32'h0, 32'h0, 2'd1, 2'd1, 32'h0000_0200, 32'h8000_0009, 7, 0, 0};
    vecs[3] = '{32'h0, VALID_BITS, VALID_BITS, 2'd3, 2'd0, 32'h0, 32'h0, 2, 0, 0};
    vecs[4] = '{32'h0, VALID_BITS, VALID_BITS, 2'd0, 2'd3, 32'h0, 32'h0, 2, 0, 0};
    vecs[5] = '{32'h0007_0706, VALID_BITS, 32'h1, 2'd0, 2'd0, 32'h1, 32'h8000_0000, 7, 1, 1};
    vecs[6] = '{32'h0007_0706, VALID_BITS, 32'h1, 2'd0, 2'd1, 32'h0, 32'h0, 2, 0, 0};

    hdrA = 128'hDDDD0004_CCCC0003_BBBB0002_44332211;
    hdrB = 128'h0BAD0004_0BAD0003_0BAD0002_0BAD0001;
    hdrC = 128'h12345678_9ABCDEF0_0F0F0F0F_A5A55A5A;

    // Reset state
    doReset;
    checkResetState("reset");

    // Table of single events, each from a fresh reset
    for (int i = 0; i < 7; i++) begin
      doReset;
      swWrite(4'd1, vecs[i].mask);
      swWrite(4'd2, vecs[i].sev);
      swWrite(4'd3, vecs[i].syserr);
      applyStimulus(vecs[i].sp, vecs[i].kd, hdrA, readyCyc, sysCnt, dpcCnt, pulseCyc, st2, fe2);
      readReg(4'd0, rd);
      checkOutput($sformatf("vec%0d_status", i), rd, vecs[i].expStatus);
      readReg(4'd4, rd);
      checkOutput($sformatf("vec%0d_first_err", i), rd, vecs[i].expFirst);
      checkOutput($sformatf("vec%0d_ready_cycle", i), readyCyc, vecs[i].expReady);
      checkOutput($sformatf("vec%0d_sys_pulses", i), sysCnt, vecs[i].expSys);
      checkOutput($sformatf("vec%0d_dpc_pulses", i), dpcCnt, vecs[i].expDpc);
    end

    // First error: cycle-accurate status, log contents, pulse timing
    doReset;
    swWrite(4'd1, 32'h0);
    swWrite(4'd3, VALID_BITS);
    applyStimulus(2'd2, 2'd2, hdrA, readyCyc, sysCnt, dpcCnt, pulseCyc, st2, fe2);
    checkOutput("first_status_c2", st2, 32'h0004_0000);
    checkOutput("first_ptr_c2", fe2, 32'h8000_0012);
    checkOutput("first_pulse_cycle", pulseCyc, 6);
    checkOutput("first_ready_cycle", readyCyc, 7);
    for (int w = 0; w < 4; w++) begin
      readReg(4'(5 + w), rd);
      checkOutput($sformatf("first_hdr_log%0d", w), rd, hdrA[w*32 +: 32]);
    end

    // Two events, log locked by the first; then re-arm via W1C
    doReset;
    swWrite(4'd1, 32'h0);
    swWrite(4'd2, 32'h0);
    pulses = 0;
    applyStimulus(2'd0, 2'd1, hdrA, readyCyc, sysCnt, dpcCnt, pulseCyc, st2, fe2);
    pulses += dpcCnt;
    applyStimulus(2'd1, 2'd0, hdrB, readyCyc, sysCnt, dpcCnt, pulseCyc, st2, fe2);
    pulses += dpcCnt;
    checkOutput("locked_ready_cycle", readyCyc, 3);
    readReg(4'd0, rd);
    checkOutput("locked_status", rd, 32'h0000_0102);
    readReg(4'd4, rd);
    checkOutput("locked_first_err", rd, 32'h8000_0001);
    for (int w = 0; w < 4; w++) begin
      readReg(4'(5 + w), rd);
      checkOutput($sformatf("locked_hdr_log%0d", w), rd, hdrA[w*32 +: 32]);
    end
    checkOutput("locked_dpc_pulses", pulses, 0);
    swWrite(4'd0, 32'h0000_0002);
    readReg(4'd4, rd);
    checkOutput("rearm_first_err", rd, 32'h0000_0001);
    readReg(4'd0, rd);
    checkOutput("rearm_status", rd, 32'h0000_0100);
    applyStimulus(2'd2, 2'd0, hdrC, readyCyc, sysCnt, dpcCnt, pulseCyc, st2, fe2);
    checkOutput("relog_ready_cycle", readyCyc, 7);
    readReg(4'd4, rd);
    checkOutput("relog_first_err", rd, 32'h8000_0010);
    readReg(4'd5, rd);
    checkOutput("relog_hdr_log0", rd, hdrC[31:0]);
    readReg(4'd8, rd);
    checkOutput("relog_hdr_log3", rd, hdrC[127:96]);

    // W1C of bit 16 on the same edge EVAL sets it: set wins
    doReset;
    swWrite(4'd1, 32'h0);
    err_space = 2'd2; err_kind = 2'd0; err_hdr = hdrB; err_valid = 1'b1;
    tick;
    err_valid = 1'b0;
    sw_wr = 1'b1; sw_addr = 4'd0; sw_wdata = 32'h0001_0000;
    tick;
    sw_wr = 1'b0;
    readReg(4'd0, rd);
    checkOutput("collide_status", rd, 32'h0001_0000);
    readReg(4'd4, rd);
    checkOutput("collide_first_err", rd, 32'h8000_0010);
    readyCyc = -1;
    for (int c = 2; c <= 20; c++) begin
      if (err_ready) begin readyCyc = c; break; end
      tick;
    end
    checkOutput("collide_ready_cycle", readyCyc, 7);

    // Reset during LOG beat 2
    doReset;
    swWrite(4'd1, 32'h0);
    swWrite(4'd3, VALID_BITS);
    pulses = 0;
    err_space = 2'd2; err_kind = 2'd2; err_hdr = hdrA; err_valid = 1'b1;
    tick;
    err_valid = 1'b0;
    for (int c = 1; c < 4; c++) begin
      if (sys_err_o || dpc_trig_o) pulses++;
      tick;
    end
    rst = 1'b1;
    if (sys_err_o || dpc_trig_o) pulses++;
    tick;
    rst = 1'b0;
    checkResetState("midlog_reset");
    for (int c = 0; c < 8; c++) begin
      if (sys_err_o || dpc_trig_o) pulses++;
      tick;
    end
    checkOutput("midlog_no_pulse", pulses, 0);

    // Randomized events against the reference model
    doReset;
    modelReset;
    for (int n = 0; n < 60; n++) begin
      logic [1:0]   sp, kd;
      logic [127:0] hdr;
      logic [4:0]   b;
      int           eReady, eSys, eDpc;
      int           nw;
      nw = $urandom_range(0, 2);
      for (int k = 0; k < nw; k++) begin
        logic [3:0]  a;
        logic [31:0] d;
        a = 4'($urandom_range(0, 9));
        d = $urandom;
        if (a == 4'd1) d = d & $urandom;
        modelWrite(a, d);
        swWrite(a, d);
      end
      sp = 2'($urandom_range(0, 3));
      kd = 2'($urandom_range(0, 3));
      hdr = {$urandom, $urandom, $urandom, $urandom};
      b = 5'(8 * sp + kd);
      eReady = 2; eSys = 0; eDpc = 0;
      if (sp != 3 && kd != 3 && !mMask[b]) begin
        mStatus[b] = 1'b1;
        eSys = int'(mSys[b]);
        eDpc = int'(mSev[b]);
        if (!mValid) begin
          mValid = 1'b1;
          mPtr = b;
          for (int w = 0; w < 4; w++) mLog[w] = hdr[w*32 +: 32];
          eReady = 7;
        end else begin
          eReady = 3;
        end
      end
      applyStimulus(sp, kd, hdr, readyCyc, sysCnt, dpcCnt, pulseCyc, st2, fe2);
      checkOutput($sformatf("rand%0d_ready_cycle", n), readyCyc, eReady);
      checkOutput($sformatf("rand%0d_sys_pulses", n), sysCnt, eSys);
      checkOutput($sformatf("rand%0d_dpc_pulses", n), dpcCnt, eDpc);
      readReg(4'd0, rd);
      checkOutput($sformatf("rand%0d_status", n), rd, mStatus);
      readReg(4'd4, rd);
      checkOutput($sformatf("rand%0d_first_err", n), rd, {mValid, 26'd0, mPtr});
      if (n % 5 == 4) begin
        for (int a = 0; a < 16; a++) begin
          logic [31:0] e;
          case (a)
            0: e = mStatus;
            1: e = mMask;
            2: e = mSev;
            3: e = mSys;
            4: e = {mValid, 26'd0, mPtr};
            5, 6, 7, 8: e = mLog[a - 5];
            default: e = 32'h0;
          endcase
          readReg(a[3:0], rd);
          checkOutput($sformatf("rand%0d_reg%0d", n, a), rd, e);
        end
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
